ecc_93_enc_fault_detc: RTL

Write-side SECDED encoder with lockstep fault detection for the 93-bit FIFO/RAM data path. It accepts 93-bit words over a valid/ready handshake and computes the 8-bit parity with two identical encoder instances whose results are compared. It returns a registered {data, parity} beat with a per-beat fault flag, a sticky fault flag and a saturating fault counter. It sits in front of the storage array, and its parity is checked by the matching 93-bit decoder on the read side.

---
 rtl/ecc_93_pkg.sv | 54 +++++
 rtl/ecc_93_enc.sv | 14 +
 rtl/ecc_93_enc_fault_detc.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ecc_93_pkg.sv
// Shared constants and parity helpers for the 93-bit SECDED write-side encoder.
// Data bits occupy non-power-of-two codeword positions 3..100.
package ecc_93_pkg;

  localparam int DATA_WIDTH   = 93;
  localparam int PARITY_WIDTH = 8;
  localparam int HAM_BITS     = 7;
  localparam int CODE_LEN     = 100;

  typedef logic [DATA_WIDTH-1:0][HAM_BITS-1:0] pos_tbl_t;
  typedef logic [HAM_BITS-1:0][DATA_WIDTH-1:0] mask_tbl_t;

  function automatic pos_tbl_t build_pos_tbl();
    pos_tbl_t t;
    int       idx;
    t   = '0;
    idx = 0;
    for (int p = 1; p <= CODE_LEN; p++) begin
      if ((p & (p - 1)) != 0) begin
        t[idx] = 7'(p);
        idx++;
      end
    end
    return t;
  endfunction

  // Codeword position of each data bit, indexed by data bit.
  localparam pos_tbl_t POS_TBL = build_pos_tbl();

  function automatic mask_tbl_t build_masks();
    mask_tbl_t m;
    m = '0;
    for (int h = 0; h < HAM_BITS; h++) begin
      for (int d = 0; d < DATA_WIDTH; d++) begin
        m[h][d] = POS_TBL[d][h];
      end
    end
    return m;
  endfunction

  localparam mask_tbl_t PAR_MASK = build_masks();

  function automatic logic [PARITY_WIDTH-1:0] secded_parity(input logic [DATA_WIDTH-1:0] data);
    logic [PARITY_WIDTH-1:0] p;
    p = {PARITY_WIDTH{1'b0}};
    for (int h = 0; h < HAM_BITS; h++) begin
      p[h] = ^(data & PAR_MASK[h]);
    end
    // Overall bit covers data plus the Hamming bits.
    p[PARITY_WIDTH-1] = (^data) ^ (^p[HAM_BITS-1:0]);
    return p;
  endfunction

endpackage

// File: rtl/ecc_93_enc.sv
// Purely combinational SECDED parity generator for one 93-bit word.
module ecc_93_enc
  import ecc_93_pkg::*;
(
  input  logic [DATA_WIDTH-1:0]   data,
  output logic [PARITY_WIDTH-1:0] parity
);

  // Parity from the shared coverage masks.
  always_comb begin
    parity = secded_parity(data);
  end

endmodule

// File: rtl/ecc_93_enc_fault_detc.sv
// Lockstep SECDED encoder: two parity instances compared, registered output beat.
// Optional error injection on data_out[1:0] when ECC_93_ERR_INJ_EN is defined.
module ecc_93_enc_fault_detc
  import ecc_93_pkg::*;
#(
  parameter int FAULT_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ecc_fault_detc_en,
  input  logic                       bypass,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      data_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [PARITY_WIDTH-1:0]    parity_out,
  output logic                       ecc_fault,
  output logic                       fault_sticky,
  output logic [FAULT_CNT_WIDTH-1:0] fault_cnt,
`ifdef ECC_93_ERR_INJ_EN
  input  logic                       inj_sbit,
  input  logic                       inj_dbit,
`endif
  input  logic                       fault_clr
);

  localparam logic [FAULT_CNT_WIDTH-1:0] CNT_MAX = {FAULT_CNT_WIDTH{1'b1}};

  logic [PARITY_WIDTH-1:0] p0_s;
  logic [PARITY_WIDTH-1:0] p1_s;
  logic [DATA_WIDTH-1:0]   data_mod_s;
  logic                    accept_s;
  logic                    mismatch_s;
  logic                    count_s;

  // Redundant instances must survive synthesis as distinct logic.
  (* keep_hierarchy = "yes", dont_touch = "true" *)
  ecc_93_enc u0 (.data(data_in), .parity(p0_s));
  (* keep_hierarchy = "yes", dont_touch = "true" *)
  ecc_93_enc u1 (.data(data_in), .parity(p1_s));

  assign in_ready   = ~out_valid | out_ready;
  assign accept_s   = in_valid & in_ready;
  assign mismatch_s = (p0_s != p1_s) & ecc_fault_detc_en & ~bypass;
  assign count_s    = accept_s & mismatch_s;

`ifdef ECC_93_ERR_INJ_EN
  logic inj_s_pend_r;
  logic inj_d_pend_r;
  logic flip_s_s;
  logic flip_d_s;

  assign flip_s_s = inj_sbit | inj_s_pend_r;
  assign flip_d_s = inj_dbit | inj_d_pend_r;

  // Apply the pending injection to the outgoing data only; parity sees clean data.
  always_comb begin
    data_mod_s = data_in;
    if (flip_d_s) begin
      data_mod_s[1:0] = ~data_in[1:0];
    end else if (flip_s_s) begin
      data_mod_s[0] = ~data_in[0];
    end else begin
      data_mod_s = data_in;
    end
  end

  // One-shot injection requests held until an accept consumes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_s_pend_r <= 1'b0;
      inj_d_pend_r <= 1'b0;
    end else if (accept_s) begin
      inj_s_pend_r <= 1'b0;
      inj_d_pend_r <= 1'b0;
    end else begin
      inj_s_pend_r <= inj_s_pend_r | inj_sbit;
      inj_d_pend_r <= inj_d_pend_r | inj_dbit;
    end
  end
`else
  assign data_mod_s = data_in;
`endif

  // Single-stage output register with valid/ready handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      data_out   <= {DATA_WIDTH{1'b0}};
      parity_out <= {PARITY_WIDTH{1'b0}};
      ecc_fault  <= 1'b0;
    end else if (accept_s) begin
      out_valid  <= 1'b1;
      data_out   <= data_mod_s;
      parity_out <= bypass ? {PARITY_WIDTH{1'b0}} : p0_s;
      ecc_fault  <= mismatch_s;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end else begin
      out_valid  <= out_valid;
    end
  end

  // Sticky flag and saturating counter; a same-cycle mismatch wins over clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_sticky <= 1'b0;
      fault_cnt    <= {FAULT_CNT_WIDTH{1'b0}};
    end else if (fault_clr) begin
      fault_sticky <= count_s;
      fault_cnt    <= count_s ? FAULT_CNT_WIDTH'(1) : {FAULT_CNT_WIDTH{1'b0}};
    end else if (count_s) begin
      fault_sticky <= 1'b1;
      fault_cnt    <= (fault_cnt == CNT_MAX) ? CNT_MAX : fault_cnt + FAULT_CNT_WIDTH'(1);
    end else begin
      fault_sticky <= fault_sticky;
      fault_cnt    <= fault_cnt;
    end
  end

endmodule
